// File: rtl/seq_tx_1011.sv
// Serial frame transmitter: emits sync header 1011 then the payload MSB first.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_tx_1011 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int              CNT_W     = $clog2(DATA_W + 1);
    localparam logic [3:0]      SYNC_PAT  = 4'b1011;
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef SEQ_TX_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_PARITY  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;
`endif

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_data_ready;
    logic               r_out_bit;
    logic               r_out_valid;
    logic               r_frame_done;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [DATA_W-1:0]  w_shift_nxt;
    logic               w_hs;
    logic               w_last_nxt;
    logic               w_bit_nxt;
    logic               w_valid_nxt;
    logic               w_ready_nxt;

`ifdef SEQ_TX_PARITY_EN
    logic               r_parity;
    logic               w_parity_nxt;
`endif

    // data_ready is only high in IDLE or on the final frame bit, so a handshake
    // always begins a new frame from either place.
    assign w_hs = data_valid & r_data_ready;

    // Next-state, counter and shift register update.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
`ifdef SEQ_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = CNT_ZERO;
                if (w_hs) begin
                    w_state_nxt = ST_SYNC;
                    w_shift_nxt = data_in;
`ifdef SEQ_TX_PARITY_EN
                    w_parity_nxt = even_parity(data_in);
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (r_cnt == SYNC_LAST) begin
                    w_state_nxt = ST_PAYLOAD;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_SYNC;
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_PAYLOAD: begin
                if (r_cnt == PAY_LAST) begin
                    w_cnt_nxt = CNT_ZERO;
`ifdef SEQ_TX_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    if (w_hs) begin
                        w_state_nxt = ST_SYNC;
                        w_shift_nxt = data_in;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
`endif
                end else begin
                    w_state_nxt = ST_PAYLOAD;
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                    w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
                end
            end
`ifdef SEQ_TX_PARITY_EN
            ST_PARITY: begin
                w_cnt_nxt = CNT_ZERO;
                if (w_hs) begin
                    w_state_nxt  = ST_SYNC;
                    w_shift_nxt  = data_in;
                    w_parity_nxt = even_parity(data_in);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Output values for the cycle being entered, registered below.
    always_comb begin
        w_bit_nxt   = 1'b0;
        w_last_nxt  = 1'b0;
        w_valid_nxt = (w_state_nxt != ST_IDLE);
        case (w_state_nxt)
            ST_SYNC: begin
                w_bit_nxt = SYNC_PAT[2'd3 - w_cnt_nxt[1:0]];
            end
            ST_PAYLOAD: begin
                w_bit_nxt = w_shift_nxt[DATA_W-1];
`ifdef SEQ_TX_PARITY_EN
                w_last_nxt = 1'b0;
`else
                w_last_nxt = (w_cnt_nxt == PAY_LAST);
`endif
            end
`ifdef SEQ_TX_PARITY_EN
            ST_PARITY: begin
                w_bit_nxt  = w_parity_nxt;
                w_last_nxt = 1'b1;
            end
`endif
            default: begin
                w_bit_nxt  = 1'b0;
                w_last_nxt = 1'b0;
            end
        endcase
        w_ready_nxt = (w_state_nxt == ST_IDLE) | w_last_nxt;
    end

    // State, datapath and registered outputs; reset abandons any frame at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= CNT_ZERO;
            r_shift      <= {DATA_W{1'b0}};
            r_data_ready <= 1'b0;
            r_out_bit    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_data_ready <= w_ready_nxt;
            r_out_bit    <= w_bit_nxt;
            r_out_valid  <= w_valid_nxt;
            r_frame_done <= w_last_nxt;
        end
    end

`ifdef SEQ_TX_PARITY_EN
    // Parity of the captured word, presented in the trailing parity cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_nxt;
        end
    end
`endif

    assign data_ready = r_data_ready;
    assign out_bit    = r_out_bit;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seq_tx_1011.sv
// Bench for seq_tx_1011 (DATA_W=8): table of payloads with hand-written frames,
// scoreboard of expected serial bits, plus reset/back-to-back/isolation sequences.
module tb_seq_tx_1011;

`ifdef SEQ_TX_PARITY_EN
    localparam int FRAME_LEN = 13;
    localparam bit HAS_PAR   = 1'b1;
`else
    localparam int FRAME_LEN = 12;
    localparam bit HAS_PAR   = 1'b0;
`endif

    typedef struct {
        logic [7:0]  data;
        logic [11:0] bits;
        logic        par;
    } vec_t;

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       out_bit;
    logic       out_valid;
    logic       frame_done;

    int   total;
    int   bad;
    int   cyc;
    int   done_last;
    int   done_prev;
    bit   mon_en;
    exp_t q[$];
    vec_t vecs[6];

    seq_tx_1011 #(.DATA_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [11:0] bits, input logic par);
        exp_t e;
        for (int i = 11; i >= 0; i--) begin
            e.b    = bits[i];
            e.last = (i == 0) && !HAS_PAR;
            q.push_back(e);
        end
        if (HAS_PAR) begin
            e.b    = par;
            e.last = 1'b1;
            q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send(input logic [7:0] d, input logic [11:0] bits, input logic par);
        int n;
        data_in    = d;
        data_valid = 1'b1;
        n = 0;
        while (!data_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("hs_wait", data_ready, 1'b1);
        if (data_ready) push_frame(bits, par);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", q.size() == 0, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic release_reset();
        @(negedge clk); #1;
        reset_n = 1'b1;
        #2;
        check("ready_before_edge", data_ready, 1'b0);
        @(posedge clk); #1;
        check("ready_after_release", data_ready, 1'b1);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_bit", 1'b1, q.size() == 0 ? 1'b0 : 1'b1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_bit", out_bit, e.b);
                    check("frame_done", frame_done, e.last);
                    check("ready_in_frame", data_ready, e.last);
                    if (frame_done) begin
                        done_prev = done_last;
                        done_last = cyc;
                    end
                end
            end else begin
                check("idle_ready", data_ready, 1'b1);
                check("idle_done", frame_done, 1'b0);
                check("idle_bit", out_bit, 1'b0);
            end
        end
    end

    initial begin
        vecs[0] = '{8'hA5, 12'b1011_1010_0101, 1'b0};
        vecs[1] = '{8'h07, 12'b1011_0000_0111, 1'b1};
        vecs[2] = '{8'h3C, 12'b1011_0011_1100, 1'b0};
        vecs[3] = '{8'h00, 12'b1011_0000_0000, 1'b0};
        vecs[4] = '{8'hFF, 12'b1011_1111_1111, 1'b0};
        vecs[5] = '{8'h81, 12'b1011_1000_0001, 1'b0};

        total = 0; bad = 0; cyc = 0; done_last = 0; done_prev = 0; mon_en = 1'b0;
        reset_n = 1'b0; data_in = 8'h00; data_valid = 1'b0;

        // Reset values while held
        repeat (2) @(posedge clk);
        #3;
        check("rst_out_bit", out_bit, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_data_ready", data_ready, 1'b0);
        release_reset();
        mon_en = 1'b1;

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, vecs[i].bits, vecs[i].par);
            data_valid = 1'b0;
            drain();
        end

        // Back-to-back: valid held, data changed on each handshake
        send(8'h00, 12'b1011_0000_0000, 1'b0);
        send(8'hFF, 12'b1011_1111_1111, 1'b0);
        data_valid = 1'b0;
        drain();
        check("b2b_spacing", (done_last - done_prev) == FRAME_LEN, 1'b1);

        // Capture isolation and ignored valid pulses while busy
        send(8'hF0, 12'b1011_1111_0000, 1'b0);
        data_in    = 8'h0F;
        data_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            data_valid = !data_ready;
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        drain();
        repeat (5) begin @(posedge clk); #1; end

        // Reset while the third payload bit is on the line
        send(8'hA5, 12'b1011_1010_0101, 1'b0);
        data_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("pre_rst_valid", out_valid, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        q.delete();
        check("mid_rst_out_bit", out_bit, 1'b0);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_frame_done", frame_done, 1'b0);
        check("mid_rst_data_ready", data_ready, 1'b0);
        repeat (2) @(posedge clk);
        release_reset();
        send(8'h3C, 12'b1011_0011_1100, 1'b0);
        data_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
